// File: rtl/spi_cmd_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
// Shared definitions for the SPI command decoder:
//   - state_t        : decoder FSM state encoding
//   - CMD_WR_BIT     : bit position of the write flag in a command byte
//   - CMD_RSV_MSB    : top bit of the reserved field (field runs down to ADDR_W)
//   - ERR_MAX        : saturation value of the error counter
//   - cmd_is_write_ok: accepts a command byte when it is a write with all
//                      reserved bits clear
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam int unsigned CMD_WR_BIT  = 7;
    localparam int unsigned CMD_RSV_MSB = 6;
    localparam logic [7:0]  ERR_MAX     = 8'd255;

    // Bits [6:addr_w] form the reserved field; shifting an all-ones mask left
    // by addr_w leaves exactly those positions set.
    function automatic logic cmd_is_write_ok(input logic [7:0] cmd_b,
                                             input int unsigned addr_w);
        logic [6:0] rsv_mask;
        rsv_mask = 7'h7F << addr_w;
        return cmd_b[CMD_WR_BIT] &&
               ((cmd_b[CMD_RSV_MSB:0] & rsv_mask) == 7'h00);
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_regfile.sv
// -----------------------------------------------------------------------------
// spi_cmd_regfile
// NREG x 8-bit register storage with one write port and a flat read image.
// Ports:
//   clk_i      : clock
//   rst_n_i    : asynchronous active-low reset, clears every register
//   wr_en_i    : write enable, one byte per asserted cycle
//   wr_addr_i  : register index to write
//   wr_data_i  : byte to store
//   regs_o     : flat image, register k at bits [8k+7:8k]
// -----------------------------------------------------------------------------
module spi_cmd_regfile #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        wr_en_i,
    input  logic [ADDR_W-1:0]           wr_addr_i,
    input  logic [7:0]                  wr_data_i,
    output logic [8*(2**ADDR_W)-1:0]    regs_o
);

    localparam int unsigned NREG = 2**ADDR_W;

    logic [7:0] mem_q [NREG];

    // Storage: cleared by reset, otherwise one byte written per enabled cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < int'(NREG); k++) begin
                mem_q[k] <= 8'h00;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end else begin
            mem_q[wr_addr_i] <= mem_q[wr_addr_i];
        end
    end

    for (genvar g = 0; g < int'(NREG); g++) begin : g_flat
        assign regs_o[8*g +: 8] = mem_q[g];
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder
// Decodes SPI byte streams into register writes. The first byte of each
// chip-select window is a command (bit7 write flag, reserved bits, start
// address); following bytes are written to the register file. Rejected
// commands bump a saturating error counter and the rest of the window is
// discarded.
//
// Build option: define SPI_CMD_AUTOINC_EN to advance the address after every
// data byte (burst to consecutive registers, wrapping at NREG-1). Without it
// every data byte overwrites the start register.
//
// Ports:
//   clk_in               : sole clock, rising edge
//   reset_n_in           : asynchronous active-low reset
//   data_in              : received byte, valid with data_valid_in
//   data_valid_in        : one-cycle byte strobe
//   transaction_valid_in : synchronised chip-select, high during a transaction
//   regs_out             : flat register image, register k at [8k+7:8k]
//   wr_strobe_out        : one-cycle pulse per committed write (latency 1)
//   wr_addr_out          : address of the write flagged by wr_strobe_out
//   err_count_out        : saturating count of rejected command bytes
// -----------------------------------------------------------------------------
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                        clk_in,
    input  logic                        reset_n_in,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid_in,
    input  logic                        transaction_valid_in,
    output logic [8*(2**ADDR_W)-1:0]    regs_out,
    output logic                        wr_strobe_out,
    output logic [ADDR_W-1:0]           wr_addr_out,
    output logic [7:0]                  err_count_out
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          err_q, err_d;
    logic                strobe_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    logic                cmd_ok_s;
    logic                cmd_bad_s;
    logic                wr_en_s;

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: chip-select dropping wins over everything, but a byte
    // arriving in that same cycle is still acted on by the output logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (transaction_valid_in) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (!transaction_valid_in) begin
                    state_d = ST_IDLE;
                end else if (data_valid_in) begin
                    state_d = cmd_is_write_ok(data_in, ADDR_W) ? ST_DATA : ST_DISCARD;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                if (!transaction_valid_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DISCARD: begin
                if (!transaction_valid_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-state byte actions: accept/reject a command, or write a data byte.
    always_comb begin
        cmd_ok_s  = 1'b0;
        cmd_bad_s = 1'b0;
        wr_en_s   = 1'b0;
        case (state_q)
            ST_CMD: begin
                if (data_valid_in) begin
                    cmd_ok_s  = cmd_is_write_ok(data_in, ADDR_W);
                    cmd_bad_s = !cmd_is_write_ok(data_in, ADDR_W);
                end else begin
                    cmd_ok_s  = 1'b0;
                    cmd_bad_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (data_valid_in) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                cmd_ok_s  = 1'b0;
                cmd_bad_s = 1'b0;
                wr_en_s   = 1'b0;
            end
        endcase
    end

    // Address pointer: loaded from an accepted command, optionally advanced
    // after each data byte (natural ADDR_W-bit wrap).
    always_comb begin
        if (cmd_ok_s) begin
            addr_d = data_in[ADDR_W-1:0];
        end else if (wr_en_s) begin
`ifdef SPI_CMD_AUTOINC_EN
            addr_d = addr_q + ADDR_ONE;
`else
            addr_d = addr_q;
`endif
        end else begin
            addr_d = addr_q;
        end
    end

    // Error counter next value, saturating at ERR_MAX.
    always_comb begin
        if (cmd_bad_s && (err_q != ERR_MAX)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    // Datapath registers: address, error count and the delayed write report.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            addr_q    <= '0;
            err_q     <= 8'd0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            strobe_q  <= wr_en_s;
            wr_addr_q <= wr_en_s ? addr_q : wr_addr_q;
        end
    end

    spi_cmd_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk_i     (clk_in),
        .rst_n_i   (reset_n_in),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (addr_q),
        .wr_data_i (data_in),
        .regs_o    (regs_out)
    );

    assign wr_strobe_out = strobe_q;
    assign wr_addr_out   = wr_addr_q;
    assign err_count_out = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_decoder
// Scoreboard bench: every data byte the reference model expects to be written
// is queued when driven; each wr_strobe_out pops one entry and compares the
// reported address and the register contents. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_cmd_decoder;

    localparam int ADDR_W = 4;
    localparam int NREG   = 2**ADDR_W;

    logic                 clk_in = 1'b0;
    logic                 reset_n_in;
    logic [7:0]           data_in;
    logic                 data_valid_in;
    logic                 transaction_valid_in;
    logic [8*NREG-1:0]    regs_out;
    logic                 wr_strobe_out;
    logic [ADDR_W-1:0]    wr_addr_out;
    logic [7:0]           err_count_out;

    spi_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
        .clk_in               (clk_in),
        .reset_n_in           (reset_n_in),
        .data_in              (data_in),
        .data_valid_in        (data_valid_in),
        .transaction_valid_in (transaction_valid_in),
        .regs_out             (regs_out),
        .wr_strobe_out        (wr_strobe_out),
        .wr_addr_out          (wr_addr_out),
        .err_count_out        (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0]         m_regs [NREG];
    logic [ADDR_W-1:0]  m_addr;
    logic               m_data_mode;
    int                 m_err;
    logic [ADDR_W+7:0]  sb [$];
    logic               prev_strobe = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
        m_addr      = '0;
        m_data_mode = 1'b0;
        m_err       = 0;
    endtask

    // All tasks start and end at a falling edge.
    task automatic begin_txn();
        transaction_valid_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        data_in       = b;
        data_valid_in = 1'b1;
        if (last) transaction_valid_in = 1'b0;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic send_cmd(input logic [7:0] c, input bit last);
        if (c[7] && (c[6:ADDR_W] == '0)) begin
            m_data_mode = 1'b1;
            m_addr      = c[ADDR_W-1:0];
        end else begin
            m_data_mode = 1'b0;
            if (m_err < 255) m_err++;
        end
        send_byte(c, last);
        if (last) m_data_mode = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input bit last);
        if (m_data_mode) begin
            sb.push_back({m_addr, b});
            m_regs[m_addr] = b;
`ifdef SPI_CMD_AUTOINC_EN
            m_addr = m_addr + 1'b1;
`endif
        end
        send_byte(b, last);
        if (last) m_data_mode = 1'b0;
    endtask

    task automatic end_txn();
        transaction_valid_in = 1'b0;
        m_data_mode          = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
    endtask

    // Write monitor: pop the scoreboard on each strobe.
    always @(negedge clk_in) begin
        logic [ADDR_W+7:0] e;
        if (reset_n_in === 1'b1) begin
            if (prev_strobe) check_eq("no_back_to_back", wr_strobe_out, 0);
            if (wr_strobe_out) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_wr", wr_strobe_out, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("wr_addr", wr_addr_out, e[ADDR_W+7:8]);
                    check_eq("wr_data", regs_out[8*int'(e[ADDR_W+7:8]) +: 8], e[7:0]);
                end
            end
        end
        prev_strobe = wr_strobe_out;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n_in           = 1'b0;
        data_in              = 8'h00;
        data_valid_in        = 1'b0;
        transaction_valid_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_eq("rst_regs",   (regs_out == '0), 1);
        check_eq("rst_strobe", wr_strobe_out, 0);
        check_eq("rst_waddr",  wr_addr_out, 0);
        check_eq("rst_err",    err_count_out, 0);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        // Byte while idle must be ignored (no CMD yet).
        data_in = 8'h81; data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
        @(negedge clk_in);

        // Burst starting at register 3.
        begin_txn();
        send_cmd(8'h83, 1'b0);
        send_data(8'h11, 1'b0);
        send_data(8'h22, 1'b0);
        end_txn();

        // Burst at the top register (wraps under auto-increment).
        begin_txn();
        send_cmd(8'h8F, 1'b0);
        send_data(8'hAA, 1'b0);
        send_data(8'hBB, 1'b0);
        end_txn();
        check_eq("reg15", regs_out[8*15 +: 8], m_regs[15]);
        check_eq("reg0",  regs_out[0 +: 8],    m_regs[0]);

        // Rejected commands: no write flag, then a reserved bit set.
        begin_txn();
        send_cmd(8'h05, 1'b0);
        send_data(8'h77, 1'b0);
        end_txn();
        begin_txn();
        send_cmd(8'hC2, 1'b0);
        send_data(8'h77, 1'b0);
        end_txn();
        check_eq("err_two", err_count_out, 2);
        check_eq("reg5",    regs_out[8*5 +: 8], 8'h00);
        check_eq("reg2",    regs_out[8*2 +: 8], 8'h00);

        // Transaction ending in CMD without a byte is not an error.
        begin_txn();
        end_txn();
        check_eq("err_empty_txn", err_count_out, 2);

        // Last data byte coincident with chip-select falling, then a new
        // transaction whose first byte must be a command.
        begin_txn();
        send_cmd(8'h81, 1'b0);
        send_data(8'h5A, 1'b1);
        begin_txn();
        send_cmd(8'h82, 1'b0);
        send_data(8'h66, 1'b0);
        end_txn();
        check_eq("reg1_edge", regs_out[8*1 +: 8], m_regs[1]);
        check_eq("reg2_next", regs_out[8*2 +: 8], m_regs[2]);

        // Reset pulsed mid-burst with chip-select still high.
        begin_txn();
        send_cmd(8'h84, 1'b0);
        send_data(8'h01, 1'b0);
        #1 reset_n_in = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_regs",   (regs_out == '0), 1);
        check_eq("async_rst_err",    err_count_out, 0);
        check_eq("async_rst_strobe", wr_strobe_out, 0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        @(negedge clk_in);
        send_cmd(8'h86, 1'b0);
        send_data(8'h99, 1'b0);
        end_txn();
        check_eq("reg6_after_rst", regs_out[8*6 +: 8], m_regs[6]);
        check_eq("reg4_after_rst", regs_out[8*4 +: 8], 8'h00);

        // 300 bad commands saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            begin_txn();
            send_cmd(8'h00, 1'b1);
        end
        check_eq("err_sat", err_count_out, m_err);
        check_eq("err_255", err_count_out, 255);

        repeat (4) @(negedge clk_in);
        for (int k = 0; k < NREG; k++) begin
            check_eq($sformatf("final_reg%0d", k), regs_out[8*k +: 8], m_regs[k]);
        end
        check_eq("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
